// File: rtl/router_pkt_gen.sv
// Framed packet source for the 1xN router input port: header {len,addr}, LFSR payload,
// XOR parity word (optionally corrupted), then a forced idle gap. Honours router busy.
module router_pkt_gen #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 2,
   parameter int                    LEN_WIDTH  = 6,
   parameter int                    NUM_DEST   = 3,
   parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(8'hB8),
   parameter int                    GAP_CYCLES = 2,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] cfg_addr,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   input  logic [DATA_WIDTH-1:0] cfg_seed,
   input  logic                  cfg_corrupt,
   input  logic                  busy,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  pkt_valid,
   output logic                  gen_busy,
   output logic                  done,
   output logic                  cfg_err,
   output logic [CNT_WIDTH-1:0]  pkt_count
);

   // The IDLE cycle that samples start is itself the last zero cycle on the bus, so the
   // GAP state only covers the remaining GAP_CYCLES-1; back-to-back packets are then
   // separated by exactly GAP_CYCLES idle bus cycles.
   localparam int GAP_HOLD = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
   localparam int GW       = (GAP_HOLD > 1) ? $clog2(GAP_HOLD) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD,
      S_PARITY,
      S_GAP
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  pkt_valid_q, pkt_valid_d;
   logic                  gen_busy_q, gen_busy_d;
   logic                  done_q, done_d;
   logic                  cfg_err_q, cfg_err_d;
   logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
   logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
   logic [DATA_WIDTH-1:0] parity_q, parity_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  corrupt_q, corrupt_d;
   logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
   logic [GW-1:0]         gap_cnt_q, gap_cnt_d;

   logic [DATA_WIDTH-1:0] hdr;
   logic [DATA_WIDTH-1:0] lfsr_adv;
   logic [DATA_WIDTH-1:0] par_acc;
   logic                  cfg_ok;

   assign hdr      = {cfg_len, cfg_addr};
   assign lfsr_adv = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
   assign par_acc  = parity_q ^ data_q;
   assign cfg_ok   = (32'(cfg_addr) < NUM_DEST) && (cfg_len != '0);

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      pkt_valid_d = pkt_valid_q;
      done_d      = 1'b0;
      cfg_err_d   = 1'b0;
      pkt_count_d = pkt_count_q;
      lfsr_d      = lfsr_q;
      parity_d    = parity_q;
      len_d       = len_q;
      corrupt_d   = corrupt_q;
      word_cnt_d  = word_cnt_q;
      gap_cnt_d   = gap_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  state_d     = S_HEADER;
                  data_d      = hdr;
                  pkt_valid_d = 1'b1;
                  parity_d    = hdr;
                  // an all-zero seed would lock the LFSR
                  lfsr_d      = (cfg_seed == '0) ? DATA_WIDTH'(1) : cfg_seed;
                  len_d       = cfg_len;
                  corrupt_d   = cfg_corrupt;
                  word_cnt_d  = '0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_HEADER: begin
            if (!busy) begin
               state_d = S_PAYLOAD;
               data_d  = lfsr_q;
            end
         end
         S_PAYLOAD: begin
            if (!busy) begin
               parity_d   = par_acc;
               lfsr_d     = lfsr_adv;
               word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
               if (word_cnt_q == len_q - LEN_WIDTH'(1)) begin
                  state_d     = S_PARITY;
                  data_d      = par_acc ^ DATA_WIDTH'(corrupt_q);
                  pkt_valid_d = 1'b0;
               end else begin
                  data_d = lfsr_adv;
               end
            end
         end
         S_PARITY: begin
            if (!busy) begin
               done_d      = 1'b1;
               pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
               data_d      = '0;
               gap_cnt_d   = '0;
               state_d     = (GAP_HOLD == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GW'(GAP_HOLD - 1)) state_d = S_IDLE;
            else                                gap_cnt_d = gap_cnt_q + GW'(1);
         end
         default: state_d = S_IDLE;
      endcase

      gen_busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         data_q      <= '0;
         pkt_valid_q <= 1'b0;
         gen_busy_q  <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         pkt_count_q <= '0;
         lfsr_q      <= '0;
         parity_q    <= '0;
         len_q       <= '0;
         corrupt_q   <= 1'b0;
         word_cnt_q  <= '0;
         gap_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         pkt_valid_q <= pkt_valid_d;
         gen_busy_q  <= gen_busy_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
         pkt_count_q <= pkt_count_d;
         lfsr_q      <= lfsr_d;
         parity_q    <= parity_d;
         len_q       <= len_d;
         corrupt_q   <= corrupt_d;
         word_cnt_q  <= word_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   assign data_in   = data_q;
   assign pkt_valid = pkt_valid_q;
   assign gen_busy  = gen_busy_q;
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;
   assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Scoreboarded bench for router_pkt_gen: stimulus queues expected bus words,
// a monitor pops and compares every word the router would accept.
module tb_router_pkt_gen;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  cfg_addr;
   logic [5:0]  cfg_len;
   logic [7:0]  cfg_seed;
   logic        cfg_corrupt;
   logic        busy;
   logic [7:0]  data_in;
   logic        pkt_valid;
   logic        gen_busy;
   logic        done;
   logic        cfg_err;
   logic [15:0] pkt_count;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  exp_q[$];

   router_pkt_gen dut (
      .clock(clock), .reset(reset), .start(start), .cfg_addr(cfg_addr),
      .cfg_len(cfg_len), .cfg_seed(cfg_seed), .cfg_corrupt(cfg_corrupt),
      .busy(busy), .data_in(data_in), .pkt_valid(pkt_valid), .gen_busy(gen_busy),
      .done(done), .cfg_err(cfg_err), .pkt_count(pkt_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_check(input string name);
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got %0h expected nothing (queue empty)", name, data_in);
      end else begin
         check(name, 32'(data_in), 32'(exp_q.pop_front()));
      end
   endtask

   // Monitor: the value on the bus just before a rising edge with busy=0 is accepted.
   initial begin
      bit in_pkt;
      in_pkt = 1'b0;
      forever begin
         @(negedge clock);
         #2;
         if (pkt_valid) begin
            in_pkt = 1'b1;
            if (!busy) pop_check("bus word");
         end else if (in_pkt && gen_busy) begin
            if (!busy) begin
               pop_check("parity word");
               in_pkt = 1'b0;
            end
         end else begin
            in_pkt = 1'b0;
         end
      end
   end

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
   endfunction

   task automatic push_model(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                             input logic c);
      logic [7:0] st, par;
      par = {l, a};
      exp_q.push_back(par);
      st = (s == 8'h00) ? 8'h01 : s;
      for (int k = 0; k < int'(l); k++) begin
         exp_q.push_back(st);
         par = par ^ st;
         st  = lfsr_next(st);
      end
      exp_q.push_back(par ^ {7'd0, c});
   endtask

   task automatic push_words(input logic [7:0] w[$]);
      foreach (w[i]) exp_q.push_back(w[i]);
   endtask

   // Called at a negedge; returns negedges from start until done is seen.
   task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                          input logic c, input int stall_at, input int stall_n,
                          output int cyc);
      cfg_addr = a; cfg_len = l; cfg_seed = s; cfg_corrupt = c;
      start = 1'b1;
      cyc = 0;
      while (1) begin
         @(negedge clock);
         start = 1'b0;
         cyc++;
         if (stall_n > 0 && cyc == stall_at)           busy = 1'b1;
         if (stall_n > 0 && cyc == stall_at + stall_n) busy = 1'b0;
         if (done) break;
         if (cyc >= 400) begin
            total++;
            bad++;
            $display("FAIL done timeout: got no done after %0d cycles expected done", cyc);
            break;
         end
      end
      busy = 1'b0;
      @(negedge clock);
      check("done pulse width", 32'(done), 0);
   endtask

   task automatic try_bad(input logic [1:0] a, input logic [5:0] l, input string name);
      cfg_addr = a; cfg_len = l; cfg_seed = 8'h11; cfg_corrupt = 1'b0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check({name, " cfg_err"}, 32'(cfg_err), 1);
      check({name, " pkt_valid"}, 32'(pkt_valid), 0);
      check({name, " gen_busy"}, 32'(gen_busy), 0);
      @(negedge clock);
      check({name, " cfg_err drop"}, 32'(cfg_err), 0);
      check({name, " pkt_valid later"}, 32'(pkt_valid), 0);
   endtask

   initial begin
      int cyc, n, d1, d2, gap;
      bit seen_hdr;
      reset = 1'b1; start = 1'b0; busy = 1'b0;
      cfg_addr = '0; cfg_len = '0; cfg_seed = '0; cfg_corrupt = 1'b0;
      repeat (2) @(negedge clock);
      check("reset data_in", 32'(data_in), 0);
      check("reset pkt_valid", 32'(pkt_valid), 0);
      check("reset gen_busy", 32'(gen_busy), 0);
      check("reset done", 32'(done), 0);
      check("reset cfg_err", 32'(cfg_err), 0);
      check("reset pkt_count", 32'(pkt_count), 0);
      reset = 1'b0;
      @(negedge clock);

      // basic packet, hand-computed words
      push_words('{8'h16, 8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hCA});
      run_pkt(2'd2, 6'd5, 8'h01, 1'b0, 0, 0, cyc);
      check("basic duration", cyc, 8);
      check("basic pkt_count", 32'(pkt_count), 1);
      repeat (2) @(negedge clock);

      // corrupted parity
      push_words('{8'h16, 8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hCB});
      run_pkt(2'd2, 6'd5, 8'h01, 1'b1, 0, 0, cyc);
      check("corrupt pkt_count", 32'(pkt_count), 2);
      repeat (2) @(negedge clock);

      // back-pressure: busy high for 3 cycles while payload word 4 is on the bus
      push_model(2'd2, 6'd16, 8'h3C, 1'b0);
      run_pkt(2'd2, 6'd16, 8'h3C, 1'b0, 6, 3, cyc);
      check("stall duration", cyc, 22);
      repeat (2) @(negedge clock);

      // length boundaries
      push_model(2'd2, 6'd14, 8'h5A, 1'b0);
      run_pkt(2'd2, 6'd14, 8'h5A, 1'b0, 0, 0, cyc);
      check("len14 duration", cyc, 17);
      repeat (2) @(negedge clock);
      push_model(2'd1, 6'd63, 8'hC3, 1'b0);
      run_pkt(2'd1, 6'd63, 8'hC3, 1'b0, 0, 0, cyc);
      check("len63 duration", cyc, 66);
      check("len63 pkt_count", 32'(pkt_count), 5);
      repeat (2) @(negedge clock);

      // zero seed substitutes 1
      push_words('{8'h08, 8'h01, 8'hB8, 8'hB1});
      run_pkt(2'd0, 6'd2, 8'h00, 1'b0, 0, 0, cyc);
      check("seed0 pkt_count", 32'(pkt_count), 6);
      repeat (2) @(negedge clock);

      // rejected configurations
      try_bad(2'd3, 6'd5, "bad addr");
      try_bad(2'd1, 6'd0, "zero len");
      check("pkt_count after rejects", 32'(pkt_count), 6);

      // reset while payload word 3 is on the bus
      push_words('{8'h16, 8'h01, 8'hB8, 8'h5C});
      cfg_addr = 2'd2; cfg_len = 6'd5; cfg_seed = 8'h01; cfg_corrupt = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         start = 1'b0;
      end
      check("word3 before abort", 32'(data_in), 32'h2E);
      reset = 1'b1;
      #1;
      check("abort data_in", 32'(data_in), 0);
      check("abort pkt_valid", 32'(pkt_valid), 0);
      check("abort gen_busy", 32'(gen_busy), 0);
      check("abort pkt_count", 32'(pkt_count), 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("queue after abort", exp_q.size(), 0);
      push_words('{8'h16, 8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hCA});
      run_pkt(2'd2, 6'd5, 8'h01, 1'b0, 0, 0, cyc);
      check("post-abort pkt_count", 32'(pkt_count), 1);
      repeat (2) @(negedge clock);

      // back-to-back with counter wrap
      force dut.pkt_count_q = 16'hFFFF;
      @(negedge clock);
      release dut.pkt_count_q;
      @(negedge clock);
      check("preload pkt_count", 32'(pkt_count), 32'hFFFF);
      push_model(2'd1, 6'd4, 8'h77, 1'b0);
      push_model(2'd1, 6'd4, 8'h77, 1'b0);
      cfg_addr = 2'd1; cfg_len = 6'd4; cfg_seed = 8'h77; cfg_corrupt = 1'b0;
      start = 1'b1;
      n = 0; d1 = -1; d2 = -1; gap = 0; seen_hdr = 1'b0;
      while (d2 < 0 && n < 400) begin
         @(negedge clock);
         n++;
         if (done) begin
            if (d1 < 0) begin
               d1 = n;
               check("wrap pkt_count", 32'(pkt_count), 0);
            end else begin
               d2 = n;
               start = 1'b0;
            end
         end
         if (d1 >= 0 && d2 < 0 && !seen_hdr) begin
            if (pkt_valid) seen_hdr = 1'b1;
            else           gap++;
         end
      end
      start = 1'b0;
      if (d2 < 0) begin
         total++;
         bad++;
         $display("FAIL back-to-back timeout: got %0d done pulses expected 2", (d1 < 0) ? 0 : 1);
      end
      check("b2b idle gap", gap, 2);
      check("b2b period", d2 - d1, 8);
      check("b2b pkt_count", 32'(pkt_count), 1);
      repeat (6) @(negedge clock);
      check("no extra packet", 32'(gen_busy), 0);
      check("scoreboard empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
